dcache_flush_ctrl: RTL and testbench

- Halt-time sequencer for the 2-way, 8-set, 2-word-block data cache.
- On halt it walks all 16 frames, writes every valid+dirty block back to memory and clears its dirty bit.
- It then writes the latched hit count to a fixed address and raises a sticky flushed flag.
- Sits between the dcache frame arrays and the dcache side of the memory controller; owns the memory port only while flushing.

---
 rtl/dcache_flush_ctrl_if.sv | 27 ++
 rtl/dcache_flush_ctrl.sv | 152 +++++++++++++++
 tb/tb_dcache_flush_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_flush_ctrl_if.sv
// rtl/dcache_flush_ctrl_if.sv - dcache-side memory write port used by the halt-time flush sequencer
//
// Signals:
//   dWEN    write request (driven by the flush controller)
//   daddr   byte address of the write
//   dstore  write data
//   dwait   memory busy; a write completes in a cycle with dWEN=1 and dwait=0
interface dcache_flush_ctrl_if;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;

    modport master (
        output dWEN,
        output daddr,
        output dstore,
        input  dwait
    );

    modport slave (
        input  dWEN,
        input  daddr,
        input  dstore,
        output dwait
    );
endinterface

// File: rtl/dcache_flush_ctrl.sv
// rtl/dcache_flush_ctrl.sv - halt-time dcache flush sequencer (write back dirty blocks, then hit count)
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   halt                 level; starts the flush when seen in IDLE
//   hit_count            running hit counter, latched at flush start
//   frame_set/frame_way  frame currently being read
//   frame_i              {valid, dirty, tag[25:0], data1, data0} of that frame
//   clr_en/clr_set/clr_way  one-cycle dirty-bit clear of the current frame
//   mem                  memory write port (master side)
//   flushed              sticky completion flag
module dcache_flush_ctrl #(
    parameter logic [31:0] COUNT_ADDR = 32'h0000_3100,
    parameter bit          COUNT_EN   = 1'b1
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        halt,
    input  logic [31:0]                 hit_count,
    output logic [2:0]                  frame_set,
    output logic                        frame_way,
    input  logic [91:0]                 frame_i,
    output logic                        clr_en,
    output logic [2:0]                  clr_set,
    output logic                        clr_way,
    dcache_flush_ctrl_if.master         mem,
    output logic                        flushed
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        WB0  = 3'd2,
        WB1  = 3'd3,
        CLR  = 3'd4,
        CNT  = 3'd5,
        DONE = 3'd6
    } state_t;

    // Where the walk goes after the last frame: the count write, or straight to DONE.
    localparam state_t TAIL = COUNT_EN ? CNT : DONE;

    state_t      state, state_n;
    logic [3:0]  ptr, ptr_n;
    logic [31:0] cnt_q, cnt_n;

    logic        frame_dirty;
    logic        last;
    logic [25:0] tag;

    assign frame_dirty = frame_i[91] & frame_i[90];
    assign last        = (ptr == 4'd15);
    assign tag         = frame_i[89:64];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            ptr   <= 4'd0;
            cnt_q <= 32'd0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt_q <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt_q;
        case (state)
            IDLE: begin
                if (halt) begin
                    ptr_n   = 4'd0;
                    cnt_n   = hit_count;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (frame_dirty) begin
                    state_n = WB0;
                end else if (last) begin
                    state_n = TAIL;
                end else begin
                    ptr_n = ptr + 4'd1;
                end
            end
            WB0: begin
                if (!mem.dwait) state_n = WB1;
            end
            WB1: begin
                if (!mem.dwait) state_n = CLR;
            end
            CLR: begin
                if (last) begin
                    state_n = TAIL;
                end else begin
                    ptr_n   = ptr + 4'd1;
                    state_n = SCAN;
                end
            end
            CNT: begin
                if (!mem.dwait) state_n = DONE;
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ptr and the frame word are held across dwait stalls, so address/data stay stable.
    always_comb begin
        frame_way  = ptr[3];
        frame_set  = ptr[2:0];
        clr_way    = ptr[3];
        clr_set    = ptr[2:0];
        clr_en     = 1'b0;
        flushed    = 1'b0;
        mem.dWEN   = 1'b0;
        mem.daddr  = 32'd0;
        mem.dstore = 32'd0;
        case (state)
            WB0: begin
                mem.dWEN   = 1'b1;
                mem.daddr  = {tag, ptr[2:0], 1'b0, 2'b00};
                mem.dstore = frame_i[31:0];
            end
            WB1: begin
                mem.dWEN   = 1'b1;
                mem.daddr  = {tag, ptr[2:0], 1'b1, 2'b00};
                mem.dstore = frame_i[63:32];
            end
            CLR: begin
                clr_en = 1'b1;
            end
            CNT: begin
                mem.dWEN   = 1'b1;
                mem.daddr  = COUNT_ADDR;
                mem.dstore = cnt_q;
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// tb/tb_dcache_flush_ctrl.sv - self-checking bench for dcache_flush_ctrl
module tb_dcache_flush_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        nrst_a, nrst_b, halt;
    logic [31:0] hit_count;
    logic        dwait_man, dwait_rnd, rnd_mode, sel_b, mask_clear;

    dcache_flush_ctrl_if bus_a ();
    dcache_flush_ctrl_if bus_b ();

    logic [2:0]  set_a, set_b, cset_a, cset_b;
    logic        way_a, way_b, cway_a, cway_b, clr_a, clr_b, fl_a, fl_b;
    logic [91:0] fi_a, fi_b;

    logic [91:0] fr_init [16];
    logic [91:0] fr_eff  [16];
    logic [15:0] clr_mask;

    wire dwait = rnd_mode ? dwait_rnd : dwait_man;
    assign bus_a.dwait = dwait;
    assign bus_b.dwait = dwait;

    dcache_flush_ctrl #(.COUNT_ADDR(32'h0000_3100), .COUNT_EN(1'b1)) dut_a (
        .CLK(CLK), .nRST(nrst_a), .halt(halt), .hit_count(hit_count),
        .frame_set(set_a), .frame_way(way_a), .frame_i(fi_a),
        .clr_en(clr_a), .clr_set(cset_a), .clr_way(cway_a),
        .mem(bus_a), .flushed(fl_a)
    );

    dcache_flush_ctrl #(.COUNT_ADDR(32'h0000_3100), .COUNT_EN(1'b0)) dut_b (
        .CLK(CLK), .nRST(nrst_b), .halt(halt), .hit_count(hit_count),
        .frame_set(set_b), .frame_way(way_b), .frame_i(fi_b),
        .clr_en(clr_b), .clr_set(cset_b), .clr_way(cway_b),
        .mem(bus_b), .flushed(fl_b)
    );

    // The idle instance is held in reset, so OR-ing both gives the active one.
    wire        w_en    = bus_a.dWEN | bus_b.dWEN;
    wire [31:0] w_addr  = bus_a.daddr | bus_b.daddr;
    wire [31:0] w_data  = bus_a.dstore | bus_b.dstore;
    wire        c_en    = clr_a | clr_b;
    wire [3:0]  c_idx   = {cway_a | cway_b, cset_a | cset_b};
    wire        fl_any  = fl_a | fl_b;
    wire        act_rst = sel_b ? nrst_b : nrst_a;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            fr_eff[i] = fr_init[i];
            if (clr_mask[i]) fr_eff[i][90] = 1'b0;
        end
    end
    assign fi_a = fr_eff[{way_a, set_a}];
    assign fi_b = fr_eff[{way_b, set_b}];

    always @(posedge CLK) begin
        if (mask_clear) clr_mask <= 16'd0;
        else if (c_en)  clr_mask[c_idx] <= 1'b1;
    end

    always @(posedge CLK) begin
        #1 dwait_rnd = 1'($urandom_range(0, 1));
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wlog [$];
    logic [3:0] clog [$];
    int         stall_viol = 0;
    logic       prev_stall = 1'b0;
    wr_t        prev_wr;

    // Record completed writes and clears; flag any change of the bus during a stall.
    always @(negedge CLK) begin
        if (!act_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!w_en || w_addr != prev_wr.addr || w_data != prev_wr.data))
                stall_viol = stall_viol + 1;
            if (w_en && !dwait) wlog.push_back('{w_addr, w_data});
            if (c_en) clog.push_back(c_idx);
            prev_stall = w_en && dwait;
            prev_wr    = '{w_addr, w_data};
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every valid+dirty frame in visit order gives two word writes,
    // then the count write when the count is enabled.
    wr_t        exp_w [$];
    logic [3:0] exp_c [$];

    task automatic build_model(input bit cen, input logic [31:0] hit);
        logic [91:0] f;
        logic [31:0] base;
        exp_w.delete();
        exp_c.delete();
        for (int i = 0; i < 16; i++) begin
            f = fr_init[i];
            if (f[91] && f[90]) begin
                base = 32'(f[89:64]) * 32'd64 + 32'(i % 8) * 32'd8;
                exp_w.push_back('{base, f[31:0]});
                exp_w.push_back('{base + 32'd4, f[63:32]});
                exp_c.push_back(4'(i));
            end
        end
        if (cen) exp_w.push_back('{32'h0000_3100, hit});
    endtask

    task automatic fill(input logic [15:0] valid, input logic [15:0] dirty, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            if (rnd)
                fr_init[i] = {valid[i], dirty[i], 26'($urandom), $urandom, $urandom};
            else if (i == 11)
                fr_init[i] = {valid[i], dirty[i], 26'hABC, 32'h2222_2222, 32'h1111_1111};
            else
                fr_init[i] = {valid[i], dirty[i], 26'h1000 + 26'(i * 53),
                              32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
        end
    endtask

    int wb, cb, sv;

    task automatic start_vec(input bit use_b, input logic [31:0] hit);
        halt       = 1'b0;
        nrst_a     = 1'b0;
        nrst_b     = 1'b0;
        dwait_man  = 1'b0;
        mask_clear = 1'b1;
        hit_count  = hit;
        @(posedge CLK); #1;
        mask_clear = 1'b0;
        sel_b      = use_b;
        if (use_b) nrst_b = 1'b1;
        else       nrst_a = 1'b1;
        @(posedge CLK); #1;
        chk("idle_flushed", 64'(fl_any), 64'd0);
        chk("idle_wen", 64'(w_en), 64'd0);
        wb = wlog.size();
        cb = clog.size();
        sv = stall_viol;
        build_model(!use_b, hit);
    endtask

    task automatic wait_flushed(input int exp_cyc);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        halt = 1'b1;
        while (!done && n < 3000) begin
            @(posedge CLK); #1;
            n++;
            halt = 1'b0;
            if (fl_any) done = 1'b1;
        end
        chk("flush_done", 64'(done), 64'd1);
        if (exp_cyc > 0) chk("latency", 64'(n), 64'(exp_cyc));
        repeat (3) @(posedge CLK);
        #1 chk("flushed_sticky", 64'(fl_any), 64'd1);
    endtask

    task automatic compare_logs();
        chk("n_writes", 64'(wlog.size() - wb), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && wb + i < wlog.size(); i++)
            chk($sformatf("write%0d", i), wlog[wb + i], exp_w[i]);
        chk("n_clears", 64'(clog.size() - cb), 64'(exp_c.size()));
        for (int i = 0; i < exp_c.size() && cb + i < clog.size(); i++)
            chk($sformatf("clear%0d", i), 64'(clog[cb + i]), 64'(exp_c[i]));
        chk("stall_hold", 64'(stall_viol - sv), 64'd0);
    endtask

    typedef struct {
        logic [15:0] valid;
        logic [15:0] dirty;
        logic [31:0] hit;
        bit          use_b;
        int          exp_writes;
        int          exp_clears;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bound;
        vecs[0] = '{16'h0000, 16'h0000, 32'd7,         1'b0,  1,  0, 18};
        vecs[1] = '{16'h0800, 16'h0800, 32'd5,         1'b0,  3,  1, 21};
        vecs[2] = '{16'h0001, 16'h0002, 32'h1234_5678, 1'b0,  1,  0, 18};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 32'd9,         1'b1, 32, 16, 65};
        vecs[4] = '{16'hA5A5, 16'hFFFF, 32'hCAFE_F00D, 1'b0, 17,  8, 42};

        rnd_mode = 1'b0; sel_b = 1'b0; mask_clear = 1'b1;
        halt = 1'b0; dwait_man = 1'b0; hit_count = 32'd0;
        nrst_a = 1'b0; nrst_b = 1'b0;
        fill(16'h0, 16'h0, 1'b0);
        #12;
        chk("rst_flushed", 64'(fl_any), 64'd0);
        chk("rst_bus", {31'd0, w_en, w_addr}, 64'd0);
        chk("rst_frame", 64'({set_a, way_a, clr_a}), 64'd0);

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].valid, vecs[v].dirty, 1'b0);
            start_vec(vecs[v].use_b, vecs[v].hit);
            wait_flushed(vecs[v].exp_cyc);
            compare_logs();
            chk("tbl_writes", 64'(wlog.size() - wb), 64'(vecs[v].exp_writes));
            chk("tbl_clears", 64'(clog.size() - cb), 64'(vecs[v].exp_clears));
            if (v == 0 && wlog.size() > wb)
                chk("cnt_only_write", wlog[wb], {32'h0000_3100, 32'd7});
            if (v == 1 && wlog.size() >= wb + 3) begin
                chk("set3_w0", wlog[wb],     {32'h0002_AF18, 32'h1111_1111});
                chk("set3_w1", wlog[wb + 1], {32'h0002_AF1C, 32'h2222_2222});
                chk("set3_cnt", wlog[wb + 2], {32'h0000_3100, 32'd5});
            end
            if (v == 1 && clog.size() > cb)
                chk("set3_clr", 64'(clog[cb]), 64'hB);
        end

        // dwait stalls: 5 cycles in WB0, 3 in WB1
        fill(16'h0004, 16'h0004, 1'b0);
        start_vec(1'b0, 32'd3);
        dwait_man = 1'b1;
        halt      = 1'b1;
        bound     = 0;
        while (!w_en && bound < 40) begin @(posedge CLK); #1; halt = 1'b0; bound++; end
        chk("wb0_reached", 64'(w_en), 64'd1);
        repeat (5) begin
            chk("wb0_stall", {w_addr, w_data}, exp_w[0]);
            @(posedge CLK); #1;
        end
        dwait_man = 1'b0;
        @(posedge CLK); #1;
        dwait_man = 1'b1;
        repeat (3) begin
            chk("wb1_stall", {w_addr, w_data}, exp_w[1]);
            @(posedge CLK); #1;
        end
        dwait_man = 1'b0;
        wait_flushed(-1);
        compare_logs();

        // reset in the middle of a WB1 stall, halt held high throughout
        fill(16'h0020, 16'h0020, 1'b0);
        start_vec(1'b0, 32'd11);
        halt  = 1'b1;
        bound = 0;
        while (!w_en && bound < 40) begin @(posedge CLK); #1; bound++; end
        chk("rst_wb0_reached", 64'(w_en), 64'd1);
        @(posedge CLK); #1;
        dwait_man = 1'b1;
        @(posedge CLK); #1;
        chk("rst_in_wb1", {w_addr, w_data}, exp_w[1]);
        nrst_a = 1'b0;
        #1;
        chk("async_rst_bus", {31'd0, w_en, w_addr}, 64'd0);
        chk("async_rst_misc", 64'({w_data, fl_any, clr_a, set_a, way_a}), 64'd0);
        @(posedge CLK); #1;
        nrst_a    = 1'b1;
        dwait_man = 1'b0;
        wait_flushed(-1);
        exp_w.push_front(exp_w[0]);
        compare_logs();

        // randomized frames, dwait and instance
        for (int r = 0; r < 8; r++) begin
            bit ub;
            ub = 1'($urandom_range(0, 1));
            fill(16'($urandom), 16'($urandom), 1'b1);
            start_vec(ub, $urandom);
            rnd_mode = 1'b1;
            wait_flushed(-1);
            rnd_mode = 1'b0;
            compare_logs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
